// File: rtl/nrisc_trace_buffer.sv
// rtl/nrisc_trace_buffer.sv - circular status tracer for the nRisc core
// Captures {cycle,pc,instr,wdata,ctrl} per clock while armed; drains oldest-first after a trigger.
module nrisc_trace_buffer #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int CTRL_W      = 11,
  parameter int DEPTH       = 16,
  parameter int CYCLE_LIMIT = 10,
  parameter int POST_TRIG   = 2,
  localparam int ENTRY_W    = 16 + ADDR_W + 2*DATA_W + CTRL_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               arm,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [DATA_W-1:0]  instr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [CTRL_W-1:0]  ctrl,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [1:0]         state,
  output logic [1:0]         trig_cause,
  output logic               overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PCNT_W = PTR_W + 1;
  localparam logic [15:0] LIMIT_M1 = 16'(CYCLE_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t              st;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [15:0]         cycle;
  logic [PCNT_W-1:0]   post_cnt;
  logic [ENTRY_W-1:0]  mem [DEPTH];

  logic               capturing;
  logic               enc_hit;
  logic               lim_hit;
  logic               full;
  logic [ENTRY_W-1:0] entry_in;

  assign capturing = ((st == S_CAPTURE) || (st == S_POST)) && !abort;
  assign enc_hit   = ctrl[0];
  assign lim_hit   = (CYCLE_LIMIT != 0) && (cycle == LIMIT_M1);
  assign full      = (count == CNT_W'(DEPTH));
  assign entry_in  = {cycle, pc, instr, wdata, ctrl};

  // Storage carries no reset; contents are only observed through rd_valid.
  always_ff @(posedge clock) begin
    if (capturing) begin
      mem[wr_ptr] <= entry_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st         <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cycle      <= '0;
      post_cnt   <= '0;
      trig_cause <= 2'd0;
      overflow   <= 1'b0;
    end else if (abort) begin
      st       <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (arm) begin
            cycle      <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            trig_cause <= 2'd0;
            st         <= S_CAPTURE;
          end
        end
        S_CAPTURE, S_POST: begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          cycle  <= cycle + 16'd1;
          // A full ring drops its oldest entry so the newest history survives.
          if (full) begin
            rd_ptr   <= rd_ptr + PTR_W'(1);
            overflow <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
          if (st == S_CAPTURE) begin
            if (enc_hit || lim_hit) begin
              trig_cause <= {lim_hit, enc_hit};
              if (POST_TRIG == 0) begin
                st <= S_DRAIN;
              end else begin
                post_cnt <= PCNT_W'(POST_TRIG);
                st       <= S_POST;
              end
            end
          end else begin
            post_cnt <= post_cnt - PCNT_W'(1);
            if (post_cnt == PCNT_W'(1)) begin
              st <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (count == '0) begin
            st <= S_IDLE;
          end else if (rd_ready) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              st <= S_IDLE;
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign state    = st;
  assign rd_valid = (st == S_DRAIN) && (count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_nrisc_trace_buffer.sv
// tb/tb_nrisc_trace_buffer.sv - directed self-checking bench for nrisc_trace_buffer
// Two instances: DEPTH=16/POST_TRIG=2 and DEPTH=4/POST_TRIG=0, sharing the tap buses.
module tb_nrisc_trace_buffer;

  logic        clock;
  logic        reset_n;
  logic        arm;
  logic        arm4;
  logic        abort;
  logic [7:0]  pc;
  logic [7:0]  instr;
  logic [7:0]  wdata;
  logic [10:0] ctrl;
  logic        rd_ready;

  logic        rd_valid,  rd_valid4;
  logic [50:0] rd_data,   rd_data4;
  logic [1:0]  state,     state4;
  logic [1:0]  trig_cause, trig_cause4;
  logic        overflow,  overflow4;

  int n_checks = 0;
  int n_pass   = 0;

  nrisc_trace_buffer #(
    .DATA_W(8), .ADDR_W(8), .CTRL_W(11), .DEPTH(16), .CYCLE_LIMIT(10), .POST_TRIG(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .arm(arm), .abort(abort),
    .pc(pc), .instr(instr), .wdata(wdata), .ctrl(ctrl), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .state(state),
    .trig_cause(trig_cause), .overflow(overflow)
  );

  nrisc_trace_buffer #(
    .DATA_W(8), .ADDR_W(8), .CTRL_W(11), .DEPTH(4), .CYCLE_LIMIT(10), .POST_TRIG(0)
  ) dut4 (
    .clock(clock), .reset_n(reset_n), .arm(arm4), .abort(abort),
    .pc(pc), .instr(instr), .wdata(wdata), .ctrl(ctrl), .rd_ready(rd_ready),
    .rd_valid(rd_valid4), .rd_data(rd_data4), .state(state4),
    .trig_cause(trig_cause4), .overflow(overflow4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  function automatic logic [50:0] ent(input int c, input logic enc);
    return {16'(c), 8'(c), ~8'(c), 8'(c * 3), 10'd0, enc};
  endfunction

  task automatic cap(input int c, input logic enc);
    pc    = 8'(c);
    instr = ~8'(c);
    wdata = 8'(c * 3);
    ctrl  = {10'd0, enc};
    step();
  endtask

  task automatic arm_main();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // Drains entries first..last from the main instance with rd_ready held high.
  task automatic drain_main(input int first, input int last, input int special);
    logic [50:0] exp;
    rd_ready = 1'b1;
    for (int c = first; c <= last; c++) begin
      if (c == special) exp = {16'd9, 8'h05, 8'hA3, 8'hA5, 11'h041};
      else exp = ent(c, 1'b0);
      check($sformatf("drain_valid_c%0d", c), 64'(rd_valid), 64'd1);
      check($sformatf("drain_data_c%0d", c), 64'(rd_data), 64'(exp));
      step();
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; arm = 1'b0; arm4 = 1'b0; abort = 1'b0;
    pc = '0; instr = '0; wdata = '0; ctrl = '0; rd_ready = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();

    check("rst_state", 64'(state), 64'd0);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_data", 64'(rd_data), 64'd0);
    check("rst_cause", 64'(trig_cause), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_state4", 64'(state4), 64'd0);

    // T1: cycle limit only, 10 + 2 entries
    arm_main();
    check("t1_armed", 64'(state), 64'd1);
    for (int c = 0; c < 12; c++) begin
      cap(c, 1'b0);
      if (c == 8) check("t1_still_capture", 64'(state), 64'd1);
      if (c == 9) check("t1_post", 64'(state), 64'd2);
      if (c < 11) check($sformatf("t1_no_valid_c%0d", c), 64'(rd_valid), 64'd0);
    end
    check("t1_drain", 64'(state), 64'd3);
    check("t1_cause", 64'(trig_cause), 64'd2);
    check("t1_ovf", 64'(overflow), 64'd0);
    drain_main(0, 11, -1);
    check("t1_idle", 64'(state), 64'd0);
    check("t1_valid_off", 64'(rd_valid), 64'd0);

    // T3 + T6: Encerra coincides with the cycle limit; back-pressure holds data
    arm_main();
    for (int c = 0; c < 12; c++) begin
      if (c == 9) begin
        pc = 8'h05; instr = 8'b10100011; wdata = 8'hA5; ctrl = 11'h041;
        step();
      end else begin
        cap(c, 1'b0);
      end
    end
    check("t3_drain", 64'(state), 64'd3);
    check("t3_cause", 64'(trig_cause), 64'd3);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t3_hold_valid_%0d", k), 64'(rd_valid), 64'd1);
      check($sformatf("t3_hold_data_%0d", k), 64'(rd_data), 64'(ent(0, 1'b0)));
      step();
    end
    drain_main(0, 11, 9);
    check("t3_idle", 64'(state), 64'd0);

    // T4: abort during POST, then re-arm restarts at cycle 0
    arm_main();
    for (int c = 0; c < 10; c++) cap(c, 1'b0);
    check("t4_post", 64'(state), 64'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_abort_idle", 64'(state), 64'd0);
    check("t4_cause_kept", 64'(trig_cause), 64'd2);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t4_no_valid_%0d", k), 64'(rd_valid), 64'd0);
      step();
    end
    arm_main();
    for (int c = 0; c < 12; c++) cap(c, 1'b0);
    check("t4_rearm_drain", 64'(state), 64'd3);
    drain_main(0, 11, -1);
    check("t4_rearm_idle", 64'(state), 64'd0);

    // T2: small ring overflows, Encerra at cycle 6 drains immediately
    arm4 = 1'b1;
    step();
    arm4 = 1'b0;
    for (int c = 0; c <= 6; c++) cap(c, c == 6);
    check("t2_drain", 64'(state4), 64'd3);
    check("t2_ovf", 64'(overflow4), 64'd1);
    check("t2_cause", 64'(trig_cause4), 64'd1);
    check("t2_main_idle", 64'(state), 64'd0);
    rd_ready = 1'b1;
    for (int c = 3; c <= 6; c++) begin
      check($sformatf("t2_valid_c%0d", c), 64'(rd_valid4), 64'd1);
      check($sformatf("t2_data_c%0d", c), 64'(rd_data4), 64'(ent(c, c == 6)));
      step();
    end
    rd_ready = 1'b0;
    check("t2_idle", 64'(state4), 64'd0);
    check("t2_valid_off", 64'(rd_valid4), 64'd0);

    // T5: arm ignored in DRAIN, then asynchronous reset mid-drain
    arm_main();
    for (int c = 0; c < 12; c++) cap(c, 1'b0);
    drain_main(0, 2, -1);
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("t5_arm_ignored", 64'(state), 64'd3);
    check("t5_data_kept", 64'(rd_data), 64'(ent(3, 1'b0)));
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_state", 64'(state), 64'd0);
    check("t5_rst_valid", 64'(rd_valid), 64'd0);
    check("t5_rst_data", 64'(rd_data), 64'd0);
    check("t5_rst_cause", 64'(trig_cause), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    check("t5_after_rst", 64'(state), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
